// File: rtl/l1d_req_resp_if.sv
// Request/response bus between the memory stage and the L1 data responder.
// The memory stage is the master; the responder is the slave.
interface l1d_req_resp_if;
   logic        l1d_req_val;
   logic [2:0]  l1d_req_cop;
   logic [2:0]  l1d_req_size;
   logic [31:0] l1d_req_addr;
   logic [31:0] l1d_req_wdata;
   logic        l1d_req_rdy;
   logic        l1d_rsp_val;
   logic [31:0] l1d_rsp_rdata;
   logic        l1d_rsp_err;

   modport master (
      output l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
      input  l1d_req_rdy, l1d_rsp_val, l1d_rsp_rdata, l1d_rsp_err
   );

   modport slave (
      input  l1d_req_val, l1d_req_cop, l1d_req_size, l1d_req_addr, l1d_req_wdata,
      output l1d_req_rdy, l1d_rsp_val, l1d_rsp_rdata, l1d_rsp_err
   );
endinterface

// File: rtl/l1d_req_resp.sv
// Single-outstanding L1 data responder: word array with byte/half/word access,
// separate cacheable/uncacheable latencies, and illegal-request error responses.
module l1d_req_resp #(
   parameter int IDX_W = 8,
   parameter int LAT_C = 1,
   parameter int LAT_U = 4
) (
   input  logic            clk,
   input  logic            n_rst,
   l1d_req_resp_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] LOAD_C = 4'(LAT_C - 1);
   localparam logic [3:0] LOAD_U = 4'(LAT_U - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;

   logic [2:0]  cap_cop, cap_size;
   logic [31:0] cap_addr, cap_wdata;

   logic [31:0] mem [2**IDX_W];

   logic [2:0]  cur_cop, cur_size;
   logic [31:0] cur_addr, cur_wdata;
   logic [IDX_W-1:0] cur_idx;
   logic        cur_err, enter_resp, mem_we;
   logic [3:0]  be;
   logic [31:0] wdata_al, rd_shift, rd_data;
   logic        unused_addr_hi;

   assign bus.l1d_req_rdy = (state_q == IDLE);
   assign bus.l1d_rsp_val = (state_q == RESP);

   // When the latency is 1 the response is set up on the accept edge itself,
   // so the request is taken straight from the bus while still idle.
   assign cur_cop   = (state_q == IDLE) ? bus.l1d_req_cop   : cap_cop;
   assign cur_size  = (state_q == IDLE) ? bus.l1d_req_size  : cap_size;
   assign cur_addr  = (state_q == IDLE) ? bus.l1d_req_addr  : cap_addr;
   assign cur_wdata = (state_q == IDLE) ? bus.l1d_req_wdata : cap_wdata;
   assign cur_idx   = cur_addr[IDX_W+1:2];
   assign unused_addr_hi = ^{cur_addr[31:IDX_W+2], cur_cop[2]};

   assign cur_err = cur_cop[1] || (cur_size > 3'd2) ||
                    ((cur_size == 3'd1) && cur_addr[0]) ||
                    ((cur_size == 3'd2) && (cur_addr[1:0] != 2'b00));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.l1d_req_val) begin
               accept  = 1'b1;
               cnt_d   = bus.l1d_req_cop[2] ? LOAD_C : LOAD_U;
               state_d = (cnt_d == 4'd0) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP);
   assign mem_we     = n_rst && enter_resp && !cur_err && cur_cop[0];

   always_comb begin
      be = 4'b0000;
      unique case (cur_size)
         3'd0:    be = 4'b0001 << cur_addr[1:0];
         3'd1:    be = cur_addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   assign wdata_al = cur_wdata << {cur_addr[1:0], 3'b000};
   assign rd_shift = mem[cur_idx] >> {cur_addr[1:0], 3'b000};

   always_comb begin
      rd_data = rd_shift;
      unique case (cur_size)
         3'd0:    rd_data = {24'h0, rd_shift[7:0]};
         3'd1:    rd_data = {16'h0, rd_shift[15:0]};
         default: rd_data = rd_shift;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q           <= IDLE;
         cnt_q             <= 4'd0;
         cap_cop           <= 3'd0;
         cap_size          <= 3'd0;
         cap_addr          <= 32'h0;
         cap_wdata         <= 32'h0;
         bus.l1d_rsp_rdata <= 32'h0;
         bus.l1d_rsp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            cap_cop   <= bus.l1d_req_cop;
            cap_size  <= bus.l1d_req_size;
            cap_addr  <= bus.l1d_req_addr;
            cap_wdata <= bus.l1d_req_wdata;
         end
         if (enter_resp) begin
            bus.l1d_rsp_err   <= cur_err;
            bus.l1d_rsp_rdata <= (cur_err || cur_cop[0]) ? 32'h0 : rd_data;
         end else begin
            bus.l1d_rsp_err   <= 1'b0;
            bus.l1d_rsp_rdata <= 32'h0;
         end
      end
   end

   // NOTE: the data array has no reset; contents survive n_rst and only the
   // control path is cleared.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[cur_idx][8*i +: 8] <= wdata_al[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_l1d_req_resp.sv
// Directed bench for l1d_req_resp: latency, byte-lane writes, read alignment,
// error responses, reset abort and index aliasing.
module tb_l1d_req_resp;
   localparam int IDX_W = 8;
   localparam int LAT_C = 1;
   localparam int LAT_U = 4;
   localparam logic [31:0] ALIAS_ADDR = 32'h10 + 32'(4 * (2**IDX_W));

   logic clk;
   logic n_rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   l1d_req_resp_if bus ();

   l1d_req_resp #(.IDX_W(IDX_W), .LAT_C(LAT_C), .LAT_U(LAT_U)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request from an idle-cycle start (#1 after an edge) and returns
   // the response plus its latency; ends #1 after the edge that returns to idle.
   task automatic do_req(input logic [2:0] cop, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat);
      int w = 0;
      while (bus.l1d_req_rdy !== 1'b1 && w < 32) begin
         @(posedge clk); #1; w++;
      end
      bus.l1d_req_val   = 1'b1;
      bus.l1d_req_cop   = cop;
      bus.l1d_req_size  = size;
      bus.l1d_req_addr  = addr;
      bus.l1d_req_wdata = wdata;
      @(posedge clk); #1;
      bus.l1d_req_val   = 1'b0;
      bus.l1d_req_wdata = 32'hA5A5_A5A5;
      lat = 1;
      while (bus.l1d_rsp_val !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      rd = bus.l1d_rsp_rdata;
      er = bus.l1d_rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      n_tests++; if (bus.l1d_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b exp 1", bus.l1d_req_rdy); end
      n_tests++; if (bus.l1d_rsp_val !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_val: got %b exp 0", bus.l1d_rsp_val); end
      n_tests++; if (bus.l1d_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", bus.l1d_rsp_rdata); end
      n_tests++; if (bus.l1d_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", bus.l1d_rsp_err); end
   endtask

   task automatic test_cacheable_rw();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b101, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL c_wr_lat: got %0d exp 1", lat); end
      n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL c_wr_rsp: got %h/%b exp 0/0", rd, er); end
      do_req(3'b100, 3'd0, 32'h13, 32'h0, rd, er, lat);
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL c_rd_lat: got %0d exp 1", lat); end
      n_tests++; if (rd !== 32'h0000_00DE || er !== 1'b0) begin n_fail++; $display("FAIL c_rd_byte13: got %h/%b exp 000000de/0", rd, er); end
      n_tests++; if (bus.l1d_rsp_val !== 1'b0 || bus.l1d_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL post_rsp_idle: got %b/%h exp 0/0", bus.l1d_rsp_val, bus.l1d_rsp_rdata); end
   endtask

   task automatic test_half_write();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b101, 3'd2, 32'h20, 32'h0, rd, er, lat);
      do_req(3'b101, 3'd1, 32'h22, 32'hFFFF_1234, rd, er, lat);
      do_req(3'b100, 3'd2, 32'h20, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h1234_0000 || er !== 1'b0) begin n_fail++; $display("FAIL half_wr_word: got %h/%b exp 12340000/0", rd, er); end
      do_req(3'b100, 3'd1, 32'h22, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL half_rd_22: got %h exp 00001234", rd); end
      do_req(3'b100, 3'd0, 32'h23, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0000_0012) begin n_fail++; $display("FAIL byte_rd_23: got %h exp 00000012", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b100, 3'd1, 32'h21, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_half_misalign: got %h/%b exp 0/1", rd, er); end
      do_req(3'b110, 3'd2, 32'h20, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_cop110: got %h/%b exp 0/1", rd, er); end
      do_req(3'b100, 3'd3, 32'h20, 32'h0, rd, er, lat);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_size3: got %b exp 1", er); end
      do_req(3'b101, 3'd2, 32'h22, 32'hFFFF_FFFF, rd, er, lat);
      n_tests++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_word_misalign_wr: got %h/%b exp 0/1", rd, er); end
      do_req(3'b111, 3'd2, 32'h20, 32'hFFFF_FFFF, rd, er, lat);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_cop111_wr: got %b exp 1", er); end
      do_req(3'b100, 3'd2, 32'h20, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h1234_0000 || er !== 1'b0) begin n_fail++; $display("FAIL err_no_modify: got %h/%b exp 12340000/0", rd, er); end
   endtask

   task automatic test_uncacheable_timing();
      logic exp_rdy, exp_val;
      logic [31:0] exp_rd;
      bus.l1d_req_val  = 1'b1;
      bus.l1d_req_cop  = 3'b000;
      bus.l1d_req_size = 3'd2;
      bus.l1d_req_addr = 32'h10;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         #1;
         exp_rdy = (k == 5);
         exp_val = (k == 4);
         exp_rd  = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
         n_tests++; if (bus.l1d_req_rdy !== exp_rdy || bus.l1d_rsp_val !== exp_val || bus.l1d_rsp_rdata !== exp_rd) begin
            n_fail++; $display("FAIL u_timing_k%0d: got rdy=%b val=%b rd=%h exp rdy=%b val=%b rd=%h", k, bus.l1d_req_rdy, bus.l1d_rsp_val, bus.l1d_rsp_rdata, exp_rdy, exp_val, exp_rd);
         end
         if (k == 5) bus.l1d_req_val = 1'b0;
         else @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b101, 3'd0, 32'h30, 32'h0000_00AA, rd, er, lat);
      do_req(3'b101, 3'd0, 32'h31, 32'h0000_00BB, rd, er, lat);
      do_req(3'b001, 3'd0, 32'h32, 32'h0000_00CC, rd, er, lat);
      n_tests++; if (lat !== LAT_U) begin n_fail++; $display("FAIL u_wr_lat: got %0d exp %0d", lat, LAT_U); end
      do_req(3'b101, 3'd0, 32'h33, 32'h0000_00DD, rd, er, lat);
      do_req(3'b100, 3'd2, 32'h30, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL b2b_word: got %h exp ddccbbaa", rd); end
      do_req(3'b000, 3'd1, 32'h32, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h0000_DDCC || lat !== LAT_U) begin n_fail++; $display("FAIL u_half_rd: got %h lat %0d exp 0000ddcc lat %0d", rd, lat, LAT_U); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b101, 3'd2, 32'h40, 32'h1122_3344, rd, er, lat);
      bus.l1d_req_val   = 1'b1;
      bus.l1d_req_cop   = 3'b001;
      bus.l1d_req_size  = 3'd2;
      bus.l1d_req_addr  = 32'h40;
      bus.l1d_req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      bus.l1d_req_val = 1'b0;
      n_tests++; if (bus.l1d_req_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got rdy %b exp 0", bus.l1d_req_rdy); end
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      n_tests++; if (bus.l1d_req_rdy !== 1'b1 || bus.l1d_rsp_val !== 1'b0) begin n_fail++; $display("FAIL abort_in_reset: got rdy=%b val=%b exp 1/0", bus.l1d_req_rdy, bus.l1d_rsp_val); end
      @(posedge clk); #1;
      n_tests++; if (bus.l1d_rsp_val !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got %b exp 0", bus.l1d_rsp_val); end
      @(posedge clk); #1;
      n_rst = 1'b1;
      n_tests++; if (bus.l1d_req_rdy !== 1'b1 || bus.l1d_rsp_val !== 1'b0) begin n_fail++; $display("FAIL abort_release: got rdy=%b val=%b exp 1/0", bus.l1d_req_rdy, bus.l1d_rsp_val); end
      do_req(3'b100, 3'd2, 32'h40, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'h1122_3344 || lat !== 1) begin n_fail++; $display("FAIL abort_no_write: got %h lat %0d exp 11223344 lat 1", rd, lat); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; logic er; int lat;
      do_req(3'b100, 3'd2, ALIAS_ADDR, 32'h0, rd, er, lat);
      n_tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL alias_rd: got %h/%b exp deadbeef/0", rd, er); end
   endtask

   initial begin
      n_rst             = 1'b0;
      bus.l1d_req_val   = 1'b0;
      bus.l1d_req_cop   = 3'b000;
      bus.l1d_req_size  = 3'd0;
      bus.l1d_req_addr  = 32'h0;
      bus.l1d_req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      n_rst = 1'b1;
      test_cacheable_rw();
      test_half_write();
      test_errors();
      test_uncacheable_timing();
      test_back_to_back();
      test_reset_abort();
      test_alias();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
